// File: rtl/div_unit_if.sv
// Handshake and operand/result bundle between the EX-stage controller and div_unit.
// The controller drives the master side; the divider implements the slave side.
interface div_unit_if;
    logic        start_i;
    logic        annul_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;

    modport master (
        output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
        input  result_o, ready_o
    );

    modport slave (
        input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring 32-bit divider, result = {remainder, quotient}.
// Define DIV_SIGNED_EN to honour signed_div_i (magnitude conversion and sign fix-up).
module div_unit (
    input  logic      clk,
    input  logic      rst,
    div_unit_if.slave bus
);
    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] part_q, part_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic        accept;
    logic [31:0] mag1, mag2;
    logic [32:0] diff;
    logic [31:0] quo_fix, rem_fix;

    assign accept = (state_q == FREE) && bus.start_i && !bus.annul_i;

    // part_q[63:32] holds the partial remainder, part_q[31:0] the dividend/quotient bits;
    // part_q[63:31] is the remainder already shifted left by one.
    assign diff = part_q[63:31] - {1'b0, dvsr_q};

`ifdef DIV_SIGNED_EN
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;

    always_comb begin
        mag1      = (bus.signed_div_i && bus.opdata1_i[31]) ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
        mag2      = (bus.signed_div_i && bus.opdata2_i[31]) ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        if (accept) begin
            neg_quo_d = bus.signed_div_i && (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
            neg_rem_d = bus.signed_div_i && bus.opdata1_i[31];
        end
        quo_fix = neg_quo_q ? (~part_q[31:0] + 32'd1)  : part_q[31:0];
        rem_fix = neg_rem_q ? (~part_q[63:32] + 32'd1) : part_q[63:32];
    end
`else
    logic sign_unused;
    assign sign_unused = bus.signed_div_i;
    assign mag1        = bus.opdata1_i;
    assign mag2        = bus.opdata2_i;
    assign quo_fix     = part_q[31:0];
    assign rem_fix     = part_q[63:32];
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        part_d   = part_q;
        dvsr_d   = dvsr_q;
        result_d = result_q;
        ready_d  = ready_q;
        case (state_q)
            FREE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (accept) begin
                    part_d  = {32'd0, mag1};
                    dvsr_d  = mag2;
                    cnt_d   = '0;
                    state_d = (bus.opdata2_i == 32'd0) ? BYZERO : ON;
                end
            end
            BYZERO: begin
                ready_d  = 1'b0;
                result_d = '0;
                state_d  = bus.annul_i ? FREE : END;
            end
            ON: begin
                if (bus.annul_i) begin
                    ready_d  = 1'b0;
                    result_d = '0;
                    state_d  = FREE;
                end else if (cnt_q == 6'd32) begin
                    result_d = {rem_fix, quo_fix};
                    ready_d  = 1'b1;
                    state_d  = END;
                end else begin
                    part_d = diff[32] ? {part_q[62:0], 1'b0}
                                      : {diff[31:0], part_q[30:0], 1'b1};
                    cnt_d  = cnt_q + 6'd1;
                end
            end
            END: begin
                // Zero-divisor results become visible here, one edge after BYZERO.
                if (bus.start_i) begin
                    ready_d = 1'b1;
                end else begin
                    ready_d  = 1'b0;
                    result_d = '0;
                    state_d  = FREE;
                end
            end
            default: state_d = FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FREE;
            cnt_q     <= '0;
            part_q    <= '0;
            dvsr_q    <= '0;
            result_q  <= '0;
            ready_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            part_q    <= part_d;
            dvsr_q    <= dvsr_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
`ifdef DIV_SIGNED_EN
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
endmodule

// File: tb/tb_div_unit.sv
// Randomized self-checking bench for div_unit against a plain-arithmetic reference model.
// Honours DIV_SIGNED_EN the same way the design does.
module tb_div_unit;
`ifdef DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    div_unit_if bus();

    div_unit dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return 64'd0;
        if (s && SIGNED_EN) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Reference: after acceptance the answer appears a fixed number of edges later
    // and stays until the controller drops start_i.
    bit          m_busy = 1'b0;
    bit          m_rdy  = 1'b0;
    bit          m_zero = 1'b0;
    int          m_left = 0;
    logic [63:0] m_val  = 64'd0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 1'b0;
            m_rdy  <= 1'b0;
        end else if (!m_busy) begin
            m_rdy <= 1'b0;
            if (bus.start_i && !bus.annul_i) begin
                m_busy <= 1'b1;
                m_zero <= (bus.opdata2_i == 32'd0);
                m_left <= (bus.opdata2_i == 32'd0) ? 2 : 33;
                m_val  <= ref_div(bus.opdata1_i, bus.opdata2_i, bus.signed_div_i);
            end
        end else if (!m_rdy) begin
            if (bus.annul_i && (m_left > 1 || !m_zero)) begin
                m_busy <= 1'b0;
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) m_rdy <= 1'b1;
            end
        end else if (!bus.start_i) begin
            m_busy <= 1'b0;
            m_rdy  <= 1'b0;
        end
    end

    always @(negedge clk) begin
        check("ready_cycle", {63'd0, bus.ready_o}, {63'd0, m_rdy});
        check("result_cycle", bus.result_o, m_rdy ? m_val : 64'd0);
    end

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input bit lit_en, input logic [63:0] lit);
        int n;
        int lat;
        int hold;
        lat = (b == 32'd0) ? 2 : 33;
        @(negedge clk);
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.signed_div_i = s;
        bus.start_i      = 1'b1;
        @(posedge clk);
        #1;
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
        bus.signed_div_i = 1'($urandom_range(0, 1));
        n = 0;
        while (!bus.ready_o && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", 64'(n), 64'(lat));
        if (lit_en) check("value", bus.result_o, lit);
        hold = $urandom_range(0, 3);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk);
    endtask

    task automatic count_ready(input int cycles, output int seen);
        seen = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (bus.ready_o) seen++;
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          seen;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd0;
        bus.opdata2_i    = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", {63'd0, bus.ready_o}, 64'd0);
        check("reset_result", bus.result_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        do_div(32'd100, 32'd7, 1'b0, 1'b1, 64'h00000002_0000000E);
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1,
               SIGNED_EN ? 64'hFFFFFFFF_FFFFFFFD : 64'h00000001_7FFFFFFC);
        do_div(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1,
               SIGNED_EN ? 64'h00000001_FFFFFFFD : 64'h00000007_00000000);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1,
               SIGNED_EN ? 64'h00000000_80000000 : 64'h80000000_00000000);
        do_div(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 64'h00000000_FFFFFFFF);
        do_div(32'd12345, 32'd0, 1'b0, 1'b1, 64'd0);
        do_div(32'hDEAD_BEEF, 32'd0, 1'b1, 1'b1, 64'd0);
        do_div(32'd1000, 32'd10, 1'b0, 1'b1, 64'h00000000_00000064);

        // Flush at iteration 10: nothing may surface afterwards.
        @(negedge clk);
        bus.opdata1_i = 32'd100000;
        bus.opdata2_i = 32'd3;
        bus.start_i   = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        bus.annul_i = 1'b0;
        count_ready(40, seen);
        check("annul_no_ready", 64'(seen), 64'd0);
        do_div(32'd1000, 32'd10, 1'b0, 1'b1, 64'h00000000_00000064);

        // Asynchronous reset in the middle of an iteration.
        @(negedge clk);
        bus.opdata1_i = 32'd5000;
        bus.opdata2_i = 32'd7;
        bus.start_i   = 1'b1;
        @(posedge clk);
        repeat (15) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("rst_on_ready", {63'd0, bus.ready_o}, 64'd0);
        check("rst_on_result", bus.result_o, 64'd0);
        bus.start_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        count_ready(40, seen);
        check("rst_on_no_ready", 64'(seen), 64'd0);

        // Asynchronous reset while a result is being held.
        @(negedge clk);
        bus.opdata1_i = 32'd100;
        bus.opdata2_i = 32'd7;
        bus.start_i   = 1'b1;
        @(posedge clk);
        repeat (34) @(posedge clk);
        #1;
        check("end_held_value", bus.result_o, 64'h00000002_0000000E);
        #2;
        rst = 1'b0;
        #1;
        check("rst_end_ready", {63'd0, bus.ready_o}, 64'd0);
        check("rst_end_result", bus.result_o, 64'd0);
        bus.start_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        count_ready(5, seen);
        check("rst_end_no_ready", 64'(seen), 64'd0);

        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = 32'd0 - $urandom_range(1, 15);
                3:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            do_div(ra, rb, 1'($urandom_range(0, 1)), 1'b0, 64'd0);
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
